// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V immediate formats, opcodes and encoder state definitions
package rv_pkg;

    // Same encoding as the decoder's ImmSrc so loader and decoder tables line up
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_R = 2'b11
    } imm_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when imm[31:msb] are all copies of the sign bit
    function automatic logic sext_fits(input logic [31:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb && imm[i] != imm[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - packs fields and a signed immediate into one I/S/B/R instruction word
module imm_pack
    import rv_pkg::*;
(
    input  imm_src_e    fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fmt)
            IMM_I: begin
                word      = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !sext_fits(imm, 11);
            end
            IMM_S: begin
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !sext_fits(imm, 11);
            end
            IMM_B: begin
                // Branch offsets are halfword aligned, so bit 0 is not encoded
                word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !sext_fits(imm, 12) || imm[0];
            end
            IMM_R: begin
                word      = {funct7, rs2, rs1, funct3, rd, opcode};
                range_err = 1'b0;
            end
            default: begin
                word      = '0;
                range_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// rtl/imm_instr_encoder.sv - run/done controlled two-stage encoder writing words to instruction memory
module imm_instr_encoder #(
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_index
);
    import rv_pkg::*;

    enc_state_e        state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  accept_cnt;
    logic [CNT_W-1:0]  write_cnt;

    logic              s1_valid;
    imm_src_e          s1_fmt;
    logic [6:0]        s1_opcode;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [2:0]        s1_funct3;
    logic [6:0]        s1_funct7;
    logic [31:0]       s1_imm;

    logic [31:0]       enc_word;
    logic              enc_err;
    logic              xfer;

    assign in_ready = (state == ST_RUN) && (accept_cnt < count_q);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == ST_RUN);

    imm_pack u_pack (
        .fmt      (s1_fmt),
        .opcode   (s1_opcode),
        .rd       (s1_rd),
        .rs1      (s1_rs1),
        .rs2      (s1_rs2),
        .funct3   (s1_funct3),
        .funct7   (s1_funct7),
        .imm      (s1_imm),
        .word     (enc_word),
        .range_err(enc_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            accept_cnt <= '0;
            write_cnt  <= '0;
            s1_valid   <= 1'b0;
            s1_fmt     <= IMM_I;
            s1_opcode  <= '0;
            s1_rd      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_funct3  <= '0;
            s1_funct7  <= '0;
            s1_imm     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_index  <= '0;
        end else begin
            mem_we   <= 1'b0;
            done     <= 1'b0;
            s1_valid <= xfer;

            if (xfer) begin
                s1_fmt     <= imm_src_e'(in_fmt);
                s1_opcode  <= in_opcode;
                s1_rd      <= in_rd;
                s1_rs1     <= in_rs1;
                s1_rs2     <= in_rs2;
                s1_funct3  <= in_funct3;
                s1_funct7  <= in_funct7;
                s1_imm     <= in_imm;
                accept_cnt <= accept_cnt + CNT_W'(1);
            end

            if (s1_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= base_q + (ADDR_W'(write_cnt) << 2);
                mem_wdata <= enc_err ? NOP_WORD : enc_word;
                write_cnt <= write_cnt + CNT_W'(1);
                if (enc_err && !err) begin
                    err       <= 1'b1;
                    err_index <= write_cnt;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        err_index <= '0;
                        if (word_count != '0) begin
                            state      <= ST_RUN;
                            base_q     <= {base_addr[ADDR_W-1:2], 2'b00};
                            count_q    <= word_count;
                            accept_cnt <= '0;
                            write_cnt  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Leave once the final word has left stage 2
                    if (write_cnt == count_q && !s1_valid) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
